// File: rtl/muldiv4_pkg.sv
// Shared constants for the muldiv4 sequencing controller: state encoding,
// opcodes and the widths derived from the 4-bit operand size.
package muldiv4_pkg;

   localparam int MD_WIDTH = 4;
   localparam int MD_ACCW  = MD_WIDTH + 1;
   localparam int MD_CNTW  = $clog2(MD_WIDTH);

   localparam logic [MD_CNTW-1:0] CNT_LAST = MD_CNTW'(MD_WIDTH - 1);

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv4_addsub.sv
// Shared 5-bit adder/subtractor; subtract inverts the operand through XOR
// gates and injects a carry-in of 1.
module muldiv4_addsub
   import muldiv4_pkg::*;
(
   input  logic [MD_ACCW-1:0]  x,
   input  logic [MD_WIDTH-1:0] y,
   input  logic                sub,
   output logic [MD_ACCW-1:0]  s
);

   logic [MD_ACCW-1:0] y_ext_s;

   // The inverted top bit makes this a true 5-bit subtract, so s[4] is the borrow
   always_comb begin
      y_ext_s = {1'b0, y} ^ {MD_ACCW{sub}};
      s       = x + y_ext_s + {{(MD_ACCW-1){1'b0}}, sub};
   end

endmodule

// File: rtl/muldiv4_seq_ctrl.sv
// Sequencing controller for the 4-bit multiply/divide datapath: shift-add
// multiply or restoring divide, one bit per cycle on a shared adder.
module muldiv4_seq_ctrl
   import muldiv4_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   state_t                state_r;
   state_t                state_next_s;
   logic                  op_r;
   logic [MD_WIDTH-1:0]   a_r;
   logic [MD_WIDTH-1:0]   b_r;
   logic [MD_WIDTH-1:0]   acc_r;
   logic [MD_WIDTH-1:0]   low_r;
   logic [MD_CNTW-1:0]    cnt_r;
   logic [MD_ACCW-1:0]    add_x_s;
   logic                  add_sub_s;
   logic [MD_ACCW-1:0]    sum_s;
   logic [MD_ACCW-1:0]    mul_s;
   logic [MD_WIDTH-1:0]   acc_step_s;
   logic [MD_WIDTH-1:0]   low_step_s;
   logic                  div_zero_s;
   logic                  busy_s;
   logic                  done_s;

   muldiv4_addsub u_addsub (
      .x   (add_x_s),
      .y   (b_r),
      .sub (add_sub_s),
      .s   (sum_s)
   );

   assign div_zero_s = (op_r == OP_DIV) && (b_r == {MD_WIDTH{1'b0}});

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = LOAD;
            else       state_next_s = IDLE;
         end
         LOAD: begin
            if (div_zero_s) state_next_s = DONE;
            else            state_next_s = ITER;
         end
         ITER: begin
            if (cnt_r == CNT_LAST) state_next_s = DONE;
            else                   state_next_s = ITER;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state, registered below
   always_comb begin
      busy_s = (state_next_s != IDLE);
      done_s = (state_next_s == DONE);
   end

   // Adder operand select: multiply adds b to hi, divide subtracts b from the shifted remainder
   always_comb begin
      add_x_s   = {1'b0, acc_r};
      add_sub_s = 1'b0;
      case (op_r)
         OP_MUL: begin
            add_x_s   = {1'b0, acc_r};
            add_sub_s = 1'b0;
         end
         OP_DIV: begin
            add_x_s   = {acc_r, low_r[MD_WIDTH-1]};
            add_sub_s = 1'b1;
         end
         default: begin
            add_x_s   = {1'b0, acc_r};
            add_sub_s = 1'b0;
         end
      endcase
   end

   // One iteration step; the stored remainder never needs bit 4 because it stays below b
   always_comb begin
      mul_s      = {1'b0, acc_r};
      acc_step_s = acc_r;
      low_step_s = low_r;
      case (op_r)
         OP_MUL: begin
            if (low_r[0]) mul_s = sum_s;
            else          mul_s = {1'b0, acc_r};
            acc_step_s = mul_s[MD_ACCW-1:1];
            low_step_s = {mul_s[0], low_r[MD_WIDTH-1:1]};
         end
         OP_DIV: begin
            if (sum_s[MD_ACCW-1] == 1'b0) begin
               acc_step_s = sum_s[MD_WIDTH-1:0];
               low_step_s = {low_r[MD_WIDTH-2:0], 1'b1};
            end else begin
               acc_step_s = {acc_r[MD_WIDTH-2:0], low_r[MD_WIDTH-1]};
               low_step_s = {low_r[MD_WIDTH-2:0], 1'b0};
            end
         end
         default: begin
            acc_step_s = acc_r;
            low_step_s = low_r;
         end
      endcase
   end

   // Operand latch, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r        <= 1'b0;
         a_r         <= {MD_WIDTH{1'b0}};
         b_r         <= {MD_WIDTH{1'b0}};
         acc_r       <= {MD_WIDTH{1'b0}};
         low_r       <= {MD_WIDTH{1'b0}};
         cnt_r       <= {MD_CNTW{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= {(2*WIDTH){1'b0}};
         div_by_zero <= 1'b0;
      end else begin
         busy <= busy_s;
         done <= done_s;
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r        <= op;
                  a_r         <= a;
                  b_r         <= b;
                  div_by_zero <= 1'b0;
               end
            end
            LOAD: begin
               acc_r <= {MD_WIDTH{1'b0}};
               low_r <= a_r;
               cnt_r <= {MD_CNTW{1'b0}};
               if (div_zero_s) begin
                  result      <= {a_r, 4'hF};
                  div_by_zero <= 1'b1;
               end
            end
            ITER: begin
               acc_r <= acc_step_s;
               low_r <= low_step_s;
               cnt_r <= cnt_r + MD_CNTW'(1);
               if (cnt_r == CNT_LAST) result <= {acc_step_s, low_step_s};
            end
            DONE: begin
               cnt_r <= {MD_CNTW{1'b0}};
            end
            default: begin
               cnt_r <= {MD_CNTW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv4_seq_ctrl.sv
// Self-checking bench for muldiv4_seq_ctrl: an arithmetic timeline model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_muldiv4_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       op;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       div_by_zero;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   muldiv4_seq_ctrl #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   function automatic logic [7:0] exp_res(input logic o, input logic [3:0] x, input logic [3:0] y);
      int xi, yi, p, q, r;
      xi = int'(x);
      yi = int'(y);
      if (!o) begin
         p = xi * yi;
         return p[7:0];
      end else if (yi == 0) begin
         return {x, 4'hF};
      end else begin
         q = xi / yi;
         r = xi % yi;
         return {r[3:0], q[3:0]};
      end
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
   endtask

   // Model: ph counts edges since the accepting edge; -1 means idle
   int         ph = -1;
   int         len = 5;
   logic [7:0] pend_res;
   logic       pend_dz;
   logic [7:0] m_res;
   logic       m_dz;
   logic       chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         ph    <= -1;
         m_res <= 8'h00;
         m_dz  <= 1'b0;
      end else if (ph < 0) begin
         if (start) begin
            ph       <= 0;
            pend_res <= exp_res(op, a, b);
            pend_dz  <= op && (b == 4'h0);
            len      <= (op && (b == 4'h0)) ? 1 : 5;
            m_dz     <= 1'b0;
         end
      end else if (ph == len) begin
         ph <= -1;
      end else begin
         ph <= ph + 1;
         if (ph + 1 == len) begin
            m_res <= pend_res;
            m_dz  <= pend_dz;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc busy", {7'd0, busy}, {7'd0, (ph >= 0)});
         chk("cyc done", {7'd0, done}, {7'd0, (ph >= 0 && ph == len)});
         chk("cyc result", result, m_res);
         chk("cyc dbz", {7'd0, div_by_zero}, {7'd0, m_dz});
      end
   end

   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input logic o, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] er, input int el, input logic ez, input string nm);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = ~o; a = ~x; b = 4'h0;
      wait_done(1, lat);
      chk({nm, " latency"}, 8'(lat), 8'(el));
      chk({nm, " result"}, result, er);
      chk({nm, " dbz"}, {7'd0, div_by_zero}, {7'd0, ez});
      @(negedge clk);
      chk({nm, " idle"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      int lat;
      int n;
      logic seen;
      reset = 1'b1; start = 1'b0; op = 1'b0; a = 4'h0; b = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("reset busy", {7'd0, busy}, 8'd0);
      chk("reset done", {7'd0, done}, 8'd0);
      chk("reset result", result, 8'h00);
      chk("reset dbz", {7'd0, div_by_zero}, 8'd0);
      reset  = 1'b0;
      chk_en = 1'b1;

      do_op(1'b0, 4'hD, 4'hB, 8'h8F, 6, 1'b0, "mul 13x11");
      do_op(1'b1, 4'hD, 4'h3, 8'h14, 6, 1'b0, "div 13/3");
      do_op(1'b1, 4'h9, 4'h0, 8'h9F, 2, 1'b1, "div 9/0");
      repeat (3) @(negedge clk);
      chk("dbz held", {7'd0, div_by_zero}, 8'd1);
      do_op(1'b1, 4'hF, 4'hF, 8'h01, 6, 1'b0, "div 15/15");

      // Back-to-back with start held high
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 4'hF; b = 4'hF;
      @(negedge clk);
      wait_done(1, lat);
      chk("b2b first latency", 8'(lat), 8'd6);
      chk("b2b first result", result, 8'hE1);
      a = 4'h0; b = 4'h9;
      @(negedge clk);
      chk("b2b gap idle", {7'd0, busy}, 8'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b second accepted", {7'd0, busy}, 8'd1);
      wait_done(2, n);
      chk("b2b done spacing", 8'(n), 8'd7);
      chk("b2b second result", result, 8'h00);
      @(negedge clk);

      // Starts during ITER and DONE are ignored
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 4'hD; b = 4'h3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 4'hF; b = 4'hF;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, lat);
      chk("ignore latency", 8'(lat), 8'd6);
      chk("ignore result", result, 8'h14);
      start = 1'b1; op = 1'b0; a = 4'h7; b = 4'h7;
      @(negedge clk);
      chk("ignore done-start", {7'd0, busy}, 8'd0);
      start = 1'b0;
      @(negedge clk);
      chk("ignore stays idle", {7'd0, busy}, 8'd0);

      // Reset in the third ITER cycle
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 4'hD; b = 4'hB;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort busy", {7'd0, busy}, 8'd0);
      chk("abort done", {7'd0, done}, 8'd0);
      chk("abort result", result, 8'h00);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("abort no done", {7'd0, seen}, 8'd0);
      do_op(1'b0, 4'h2, 4'h3, 8'h06, 6, 1'b0, "mul 2x3");

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
